// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity selector
// constants and the transmit FSM state type.
package uart_pkg;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_NONE = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pointers wrap naturally, and an
// explicit occupancy count (one bit wider than the pointers) tells full from
// empty. A push into a full FIFO and a pop from an empty FIFO are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty
);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign push    = wr_en && (count != FULL_COUNT);
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array: only accepted pushes write, so its contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: words are queued in a small FIFO and sent as
// start / BITS_N data (LSB first) / optional parity / stop frames, back to back
// while the FIFO has data. Defining UART_TX_STATUS_EN adds the fifo_count_out
// and overflow_out status ports.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_N-1:0] data_tx,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              uart_out,
  output logic              busy_out
`ifdef UART_TX_STATUS_EN
  ,
  output logic [AW:0]       fifo_count_out,
  output logic              overflow_out
`endif
);

  localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int IW = $clog2(BITS_N);

  localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST  = TW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [IW-1:0] DATA_LAST  = IW'(BITS_N - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD_FLIP   = (PARITY_TYPE == PARITY_ODD);
  localparam logic          HAS_PARITY = (PARITY_TYPE != PARITY_NONE);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_next;
  logic [IW-1:0]     bit_idx;
  logic [IW-1:0]     bit_idx_next;
  logic [BITS_N-1:0] shift;
  logic [BITS_N-1:0] shift_next;
  logic              par;
  logic              par_next;
  logic              line;
  logic              line_next;
  logic              pop;

  logic [BITS_N-1:0] head;
  logic [AW:0]       fifo_count;
  logic              fifo_empty;

  sync_fifo #(
    .WIDTH (BITS_N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (data_tx),
    .wr_en   (valid_in),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // Ready depends only on the registered count, so a pop this cycle frees a
  // slot only from the next cycle on.
  assign ready_out = (fifo_count != FULL_COUNT);
  assign busy_out  = (state != IDLE) || !fifo_empty;
  assign uart_out  = line;

  // State, bit timer, shifter, parity bit and the registered serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      line    <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      par     <= par_next;
      line    <= line_next;
    end
  end

  // Frame sequencing; the line level is derived from where the FSM goes next
  // so that uart_out changes exactly on the edge that enters each bit.
  always_comb begin
    state_next   = state;
    timer_next   = timer + TIMER_ONE;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    par_next     = par;
    pop          = 1'b0;
    line_next    = 1'b1;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = head;
          par_next   = (^head) ^ ODD_FLIP;
          state_next = START;
        end
      end
      START: begin
        if (timer == BIT_LAST) begin
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          shift_next = shift >> 1;
          if (bit_idx == DATA_LAST) begin
            state_next = HAS_PARITY ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_ONE;
          end
        end
      end
      PARITY: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (timer == STOP_LAST) begin
          timer_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = head;
            par_next   = (^head) ^ ODD_FLIP;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        timer_next = '0;
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shift_next[0];
      PARITY:  line_next = par_next;
      default: line_next = 1'b1;
    endcase
  end

`ifdef UART_TX_STATUS_EN
  assign fifo_count_out = fifo_count;

  // Sticky flag for any write offered while the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_out <= 1'b0;
    end else if (valid_in && !ready_out) begin
      overflow_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered with three configurations (even/1 stop,
// odd/1 stop, no parity/2 stops), all at 4 clocks per bit. Status ports are
// checked when UART_TX_STATUS_EN is defined.
module tb_uart_tx_buffered;

  localparam int C = 4;

  typedef logic bitq_t[$];

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [15:0] bits;
    int          nbits;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] d0, d1, d2;
  logic v0, v1, v2;
  logic r0, r1, r2;
  logic u0, u1, u2;
  logic b0, b1, b2;
`ifdef UART_TX_STATUS_EN
  logic [2:0] fc0, fc1, fc2;
  logic ov0, ov1, ov2;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] rnd_exp[$];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .data_tx(d0), .valid_in(v0), .ready_out(r0), .uart_out(u0), .busy_out(b0)
`ifdef UART_TX_STATUS_EN
    , .fifo_count_out(fc0), .overflow_out(ov0)
`endif
  );

  uart_tx_buffered #(.CLKS_PER_BIT(C), .BITS_N(8), .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .data_tx(d1), .valid_in(v1), .ready_out(r1), .uart_out(u1), .busy_out(b1)
`ifdef UART_TX_STATUS_EN
    , .fifo_count_out(fc1), .overflow_out(ov1)
`endif
  );

  uart_tx_buffered #(.CLKS_PER_BIT(C), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .data_tx(d2), .valid_in(v2), .ready_out(r2), .uart_out(u2), .busy_out(b2)
`ifdef UART_TX_STATUS_EN
    , .fifo_count_out(fc2), .overflow_out(ov2)
`endif
  );

  function automatic logic get_line(input int k);
    case (k)
      0: return u0;
      1: return u1;
      default: return u2;
    endcase
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      0: return b0;
      1: return b1;
      default: return b2;
    endcase
  endfunction

  function automatic logic get_ready(input int k);
    case (k)
      0: return r0;
      1: return r1;
      default: return r2;
    endcase
  endfunction

  // Reference frame from the protocol rules: start, data LSB first,
  // parity that makes the total ones even (or odd), then the stop bits.
  function automatic bitq_t frame_bits(input int k, input logic [7:0] d);
    bitq_t q;
    int ones;
    q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (k == 0) q.push_back(logic'(ones % 2));
    if (k == 1) q.push_back(logic'((ones + 1) % 2));
    q.push_back(1'b1);
    if (k == 2) q.push_back(1'b1);
    return q;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setIn(input int k, input logic v, input logic [7:0] d);
    case (k)
      0: begin v0 = v; d0 = d; end
      1: begin v1 = v; d1 = d; end
      default: begin v2 = v; d2 = d; end
    endcase
  endtask

  // Offer a word at a falling edge and hold it until a rising edge accepts it.
  task automatic pushWord(input int k, input logic [7:0] w, output bit ok);
    int waited = 0;
    ok = 1'b0;
    setIn(k, 1'b1, w);
    while (!get_ready(k) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (get_ready(k)) begin
      @(negedge clk);
      ok = 1'b1;
    end else begin
      checkOutput("push_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] w);
    bit ok;
    pushWord(k, w, ok);
    setIn(k, 1'b0, 8'h00);
  endtask

  // Compare every clock of every bit against the expected bit stream. With
  // sync set, the first low sample seen (bounded wait) is sample zero.
  task automatic checkFrame(input int k, input bitq_t exp, input string name, input bit sync);
    int waited = 0;
    logic val;
    if (sync) begin
      while (get_line(k) !== 1'b0 && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      if (get_line(k) !== 1'b0) begin
        checkOutput({name, "_start_timeout"}, 32'd1, 32'd0);
        return;
      end
    end
    for (int b = 0; b < exp.size(); b++) begin
      val = exp[b];
      for (int s = 0; s < C; s++) begin
        if (!(sync && b == 0 && s == 0)) @(negedge clk);
        if (get_line(k) !== exp[b]) val = get_line(k);
      end
      checkOutput($sformatf("%s_bit%0d", name, b), 32'(val), 32'(exp[b]));
    end
  endtask

  // Serial decoder for dut0: sample mid-bit and compare against the queue of
  // accepted words, plus start, parity and stop bits.
  task automatic decodeFrames(input int n);
    logic [10:0] smp;
    logic [7:0]  w;
    int waited;
    int pos;
    for (int f = 0; f < n; f++) begin
      waited = 0;
      while (get_line(0) !== 1'b0 && waited < 3000) begin
        @(negedge clk);
        waited++;
      end
      if (get_line(0) !== 1'b0) begin
        checkOutput("rx_start_timeout", 32'd1, 32'd0);
        return;
      end
      pos = 0;
      for (int b = 0; b < 11; b++) begin
        while (pos < b * C + C / 2) begin
          @(negedge clk);
          pos++;
        end
        smp[b] = get_line(0);
      end
      if (rnd_exp.size() == 0) begin
        checkOutput("rx_unexpected_frame", 32'(smp[8:1]), 32'hFFFF_FFFF);
      end else begin
        w = rnd_exp.pop_front();
        checkOutput($sformatf("rx_data%0d", f), 32'(smp[8:1]), 32'(w));
        checkOutput($sformatf("rx_start%0d", f), 32'(smp[0]), 32'd0);
        checkOutput($sformatf("rx_parity%0d", f), 32'(smp[9]), 32'($countones(w) % 2));
        checkOutput($sformatf("rx_stop%0d", f), 32'(smp[10]), 32'd1);
      end
    end
  endtask

  initial begin
    vec_t  vecs[7];
    bitq_t q;
    bitq_t burst;
    logic [7:0] bw[5];
    bit ok;
    bit resumed;

    vecs[0] = '{dut: 0, data: 8'hA5, bits: 16'h054A, nbits: 11};
    vecs[1] = '{dut: 0, data: 8'h00, bits: 16'h0400, nbits: 11};
    vecs[2] = '{dut: 0, data: 8'hFF, bits: 16'h05FE, nbits: 11};
    vecs[3] = '{dut: 1, data: 8'h00, bits: 16'h0600, nbits: 11};
    vecs[4] = '{dut: 1, data: 8'h01, bits: 16'h0402, nbits: 11};
    vecs[5] = '{dut: 2, data: 8'h5A, bits: 16'h06B4, nbits: 11};
    vecs[6] = '{dut: 2, data: 8'hFF, bits: 16'h07FE, nbits: 11};
    bw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst = 1'b1;
    setIn(0, 1'b0, 8'h00);
    setIn(1, 1'b0, 8'h00);
    setIn(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_line%0d", k), 32'(get_line(k)), 32'd1);
      checkOutput($sformatf("rst_busy%0d", k), 32'(get_busy(k)), 32'd0);
      checkOutput($sformatf("rst_ready%0d", k), 32'(get_ready(k)), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-frame vectors");
    for (int i = 0; i < 7; i++) begin
      q = {};
      for (int b = 0; b < vecs[i].nbits; b++) q.push_back(vecs[i].bits[b]);
      applyStimulus(vecs[i].dut, vecs[i].data);
      checkOutput($sformatf("v%0d_idle_before_start", i), 32'(get_line(vecs[i].dut)), 32'd1);
      checkFrame(vecs[i].dut, q, $sformatf("v%0d", i), 1'b0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_end_busy", i), 32'(get_busy(vecs[i].dut)), 32'd0);
      checkOutput($sformatf("v%0d_end_line", i), 32'(get_line(vecs[i].dut)), 32'd1);
    end

    $display("[TB] burst of five, then a write while full");
    burst = {};
    for (int i = 0; i < 5; i++) begin
      q = frame_bits(0, bw[i]);
      foreach (q[j]) burst.push_back(q[j]);
    end
    fork
      begin
        for (int i = 0; i < 5; i++) pushWord(0, bw[i], ok);
        setIn(0, 1'b0, 8'h00);
        checkOutput("full_ready_low", 32'(r0), 32'd0);
`ifdef UART_TX_STATUS_EN
        checkOutput("full_count", 32'(fc0), 32'd4);
        checkOutput("overflow_clear_before_drop", 32'(ov0), 32'd0);
`endif
        setIn(0, 1'b1, 8'h3C);
        @(negedge clk);
        setIn(0, 1'b0, 8'h00);
`ifdef UART_TX_STATUS_EN
        checkOutput("overflow_set", 32'(ov0), 32'd1);
        checkOutput("count_after_drop", 32'(fc0), 32'd4);
`endif
      end
      checkFrame(0, burst, "burst", 1'b1);
    join
    @(negedge clk);
    checkOutput("burst_end_busy", 32'(b0), 32'd0);

    $display("[TB] reset during data bit 3");
    applyStimulus(0, 8'hA5);
    pushWord(0, 8'h11, ok);
    setIn(0, 1'b0, 8'h00);
    repeat (4 * C + 1) @(negedge clk);
    checkOutput("pre_reset_bit3", 32'(u0), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midframe_rst_line", 32'(u0), 32'd1);
    checkOutput("midframe_rst_busy", 32'(b0), 32'd0);
    checkOutput("midframe_rst_ready", 32'(r0), 32'd1);
`ifdef UART_TX_STATUS_EN
    checkOutput("midframe_rst_count", 32'(fc0), 32'd0);
    checkOutput("midframe_rst_overflow", 32'(ov0), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    resumed = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (u0 !== 1'b1 || b0 !== 1'b0) resumed = 1'b1;
    end
    checkOutput("no_resume_after_reset", 32'(resumed), 32'd0);
    q = {};
    for (int b = 0; b < 11; b++) begin
      logic [15:0] v3c;
      v3c = 16'h0478;
      q.push_back(v3c[b]);
    end
    applyStimulus(0, 8'h3C);
    checkOutput("post_reset_idle", 32'(u0), 32'd1);
    checkFrame(0, q, "post_reset", 1'b0);
    @(negedge clk);
    checkOutput("post_reset_end_busy", 32'(b0), 32'd0);

    $display("[TB] random words with random gaps");
    rnd_exp = {};
    fork
      begin
        logic [7:0] w;
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          w = 8'($urandom);
          pushWord(0, w, ok);
          setIn(0, 1'b0, 8'h00);
          if (ok) rnd_exp.push_back(w);
        end
      end
      decodeFrames(20);
    join
    repeat (2 * C) @(negedge clk);
    checkOutput("random_all_received", 32'(rnd_exp.size()), 32'd0);
    checkOutput("random_end_busy", 32'(b0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (115200 baud at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter BITS_N, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_TYPE, default 0: 0 = even, 1 = odd, 2 = none.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1, 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: transmit buffer entries; power of two, >= 2.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port data_tx  input  BITS_N  word to transmit.
REQ-009 SHALL have port valid_in  input  1  data_tx valid.
REQ-010 SHALL have port ready_out  output  1  FIFO not full; a write is accepted when valid_in && ready_out at a rising edge.
REQ-011 SHALL have port uart_out  output  1  serial line; idles high.
REQ-012 SHALL have port busy_out  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 SHALL store accepted words in a FIFO_DEPTH-entry FIFO, in order, with no loss.
REQ-014 SHALL use a transmit FSM with states IDLE, START, DATA, PARITY, STOP; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 IDLE with a non-empty FIFO: at the next edge, SHALL pop the head word into the shift register, enter START and drive uart_out low.
REQ-016 A write into an empty FIFO in IDLE at edge N SHALL produce the start-bit falling edge at edge N+1.
REQ-017 DATA SHALL send BITS_N bits, LSB first.
REQ-018 PARITY SHALL be skipped when PARITY_TYPE = 2; otherwise it SHALL send the XOR of the data bits (even), or its inverse (odd).
REQ-019 STOP SHALL hold uart_out high for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 At the end of STOP with a non-empty FIFO, SHALL go directly to START, with no idle gap between frames; otherwise SHALL go to IDLE.
REQ-021 ready_out SHALL be combinational from the FIFO count (count < FIFO_DEPTH); a pop in the same cycle SHALL NOT raise ready_out until the next cycle.
REQ-022 A write while ready_out = 0 SHALL be dropped without corrupting the FIFO.
REQ-023 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-025 While rst = 1, SHALL force the FSM to IDLE, empty the FIFO, and drive uart_out = 1, busy_out = 0 and ready_out = 1, all asynchronously.
REQ-026 Reset mid-frame SHALL abort the frame immediately; no partial frame SHALL resume after reset is released.

Configuration
REQ-027 With UART_TX_STATUS_EN defined, SHALL add two outputs: fifo_count_out (log2(FIFO_DEPTH)+1 bits, current count) and overflow_out (1 bit, sticky, set by a dropped write, cleared only by rst).
REQ-028 Without UART_TX_STATUS_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 The package uart_pkg SHALL hold the parity-type constants (PARITY_EVEN, PARITY_ODD, PARITY_NONE) and the tx_state_t enum.
REQ-030 The FIFO SHALL be a separate sub-module, sync_fifo, parametrised by width and depth.

Verification (CLKS_PER_BIT = 4, BITS_N = 8, FIFO_DEPTH = 4 unless stated)
REQ-031 Even parity, write 0xA5 -> uart_out sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles; start bit begins 1 cycle after the write.
REQ-032 Odd parity, write 0x00 -> parity bit = 1; PARITY_TYPE = 2, STOP_BITS = 2 -> frame length = 11 bits = 44 cycles.
REQ-033 Burst of 5 writes while idle -> first 4 accepted (the first is popped immediately), 5th accepted once a slot frees; frames back-to-back, no high gap beyond the stop bits.
REQ-034 Fill the FIFO, then write 0x3C with ready_out = 0 -> 0x3C never transmitted; overflow_out = 1 (with UART_TX_STATUS_EN).
REQ-035 Assert rst during DATA bit 3 -> uart_out = 1 at once, busy_out = 0, fifo_count_out = 0; after release, the next write transmits correctly.
REQ-036 Random 20 words, random valid_in gaps -> the serial decoder output equals the input order and values, with correct parity and stop bits.
